// File: rtl/reg_file_32x32.sv
// MIPS register file: 32 x 32-bit, two combinational read ports, one clocked write port.
// r0 is hardwired to zero; same-cycle write-back is forwarded to the read ports.
module reg_file_32x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  wr_en;

    // A write to r0 is not a write at all: it neither stores nor bypasses.
    assign wr_en = RegWrite && (WriteReg != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[WriteReg] <= WriteData;
        end
    end

    // Reset also masks the bypass path so outputs read zero for its whole duration.
    always_comb begin
        ReadData1 = '0;
        if (!reset && (ReadReg1 != '0)) begin
            if (wr_en && (WriteReg == ReadReg1)) begin
                ReadData1 = WriteData;
            end else begin
                ReadData1 = regs[ReadReg1];
            end
        end
    end

    always_comb begin
        ReadData2 = '0;
        if (!reset && (ReadReg2 != '0)) begin
            if (wr_en && (WriteReg == ReadReg2)) begin
                ReadData2 = WriteData;
            end else begin
                ReadData2 = regs[ReadReg2];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_32x32.sv
// Self-checking bench for reg_file_32x32: directed scenarios plus randomized traffic
// compared against an array model of the architectural register state.
`timescale 1ns/100ps
module tb_reg_file_32x32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  ReadReg1 = '0;
    logic [4:0]  ReadReg2 = '0;
    logic [4:0]  WriteReg = '0;
    logic [31:0] WriteData = '0;
    logic        RegWrite = 1'b0;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] model [32];
    logic [31:0] exp_q [$];

    reg_file_32x32 dut (
        .clk      (clk),
        .reset    (reset),
        .ReadReg1 (ReadReg1),
        .ReadReg2 (ReadReg2),
        .WriteReg (WriteReg),
        .WriteData(WriteData),
        .RegWrite (RegWrite),
        .ReadData1(ReadData1),
        .ReadData2(ReadData2)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish, required finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (reset || idx == 5'd0) return 32'h0;
        if (RegWrite && WriteReg == idx) return WriteData;
        return model[idx];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        RegWrite  = we;
        WriteReg  = wa;
        WriteData = wd;
        ReadReg1  = r1;
        ReadReg2  = r2;
    endtask

    // Advance one cycle (from negedge to next negedge), committing the write to the model.
    task automatic tick();
        @(posedge clk);
        if (!reset && RegWrite && WriteReg != 5'd0) model[WriteReg] = WriteData;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        // preload nonzero contents, confirm they are there, then reset mid-cycle
        drive(1'b1, 5'd12, 32'hCAFEF00D, 5'd0, 5'd0); tick();
        drive(1'b1, 5'd31, 32'h0BADF00D, 5'd0, 5'd0); tick();
        drive(1'b0, 5'd0, 32'h0, 5'd12, 5'd31); #1;
        n_cmp++;
        if (ReadData1 !== 32'hCAFEF00D) begin
            n_err++; $display("FAIL reset_preload_r12: got %h, required %h", ReadData1, 32'hCAFEF00D);
        end
        n_cmp++;
        if (ReadData2 !== 32'h0BADF00D) begin
            n_err++; $display("FAIL reset_preload_r31: got %h, required %h", ReadData2, 32'h0BADF00D);
        end
        #1 reset = 1'b1;
        model_clear();
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i);
            ReadReg2 = 5'(31 - i);
            #0.1;
            n_cmp++;
            if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
                n_err++;
                $display("FAIL reset_sweep idx %0d: got %h/%h, required 0/0", i, ReadData1, ReadData2);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd12, 5'd31); #1;
        n_cmp++;
        if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
            n_err++; $display("FAIL reset_after_release: got %h/%h, required 0/0", ReadData1, ReadData2);
        end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0); tick();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5); #1;
        n_cmp++;
        if (ReadData1 !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL write_read_rd1: got %h, required %h", ReadData1, 32'hDEADBEEF);
        end
        n_cmp++;
        if (ReadData2 !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL write_read_rd2: got %h, required %h", ReadData2, 32'hDEADBEEF);
        end
        @(negedge clk);
    endtask

    task automatic test_r0();
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0); #1;
        n_cmp++;
        if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
            n_err++; $display("FAIL r0_no_bypass: got %h/%h, required 0/0", ReadData1, ReadData2);
        end
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd5); #1;
        n_cmp++;
        if (ReadData1 !== 32'h0) begin
            n_err++; $display("FAIL r0_after_write: got %h, required 0", ReadData1);
        end
        n_cmp++;
        if (ReadData2 !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL r0_write_clobbered_r5: got %h, required %h", ReadData2, 32'hDEADBEEF);
        end
        @(negedge clk);
    endtask

    task automatic test_bypass();
        drive(1'b1, 5'd7, 32'h00000011, 5'd0, 5'd0); tick();
        drive(1'b1, 5'd7, 32'h00000022, 5'd5, 5'd7); #1;
        n_cmp++;
        if (ReadData2 !== 32'h00000022) begin
            n_err++; $display("FAIL bypass_before_edge: got %h, required %h", ReadData2, 32'h22);
        end
        n_cmp++;
        if (ReadData1 !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL bypass_other_port: got %h, required %h", ReadData1, 32'hDEADBEEF);
        end
        @(posedge clk);
        model[7] = 32'h00000022;
        #1;
        n_cmp++;
        if (ReadData2 !== 32'h00000022) begin
            n_err++; $display("FAIL bypass_after_edge: got %h, required %h", ReadData2, 32'h22);
        end
        @(negedge clk);
        drive(1'b0, 5'd7, 32'h00000033, 5'd7, 5'd7); #1;
        n_cmp++;
        if (ReadData1 !== 32'h00000022 || ReadData2 !== 32'h00000022) begin
            n_err++; $display("FAIL bypass_stored: got %h/%h, required 22/22", ReadData1, ReadData2);
        end
        @(negedge clk);
    endtask

    task automatic test_no_write();
        drive(1'b0, 5'd9, 32'h12345678, 5'd9, 5'd9); #1;
        n_cmp++;
        if (ReadData1 !== 32'h0) begin
            n_err++; $display("FAIL no_write_no_bypass: got %h, required 0", ReadData1);
        end
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9); #1;
        n_cmp++;
        if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
            n_err++; $display("FAIL no_write_r9: got %h/%h, required 0/0", ReadData1, ReadData2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        drive(1'b1, 5'd3, 32'hA5A5A5A5, 5'd0, 5'd0); tick();
        drive(1'b1, 5'd3, 32'h00000001, 5'd3, 5'd3); #1;
        n_cmp++;
        if (ReadData1 !== 32'h00000001) begin
            n_err++; $display("FAIL midrst_bypass_pre: got %h, required 1", ReadData1);
        end
        #1 reset = 1'b1;
        model_clear();
        #0.1;
        n_cmp++;
        if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
            n_err++; $display("FAIL midrst_immediate: got %h/%h, required 0/0", ReadData1, ReadData2);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (ReadData1 !== 32'h0) begin
            n_err++; $display("FAIL midrst_held_edge: got %h, required 0", ReadData1);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0); #1;
        n_cmp++;
        if (ReadData1 !== 32'h0) begin
            n_err++; $display("FAIL midrst_write_lost: got %h, required 0", ReadData1);
        end
        drive(1'b1, 5'd3, 32'h00000001, 5'd0, 5'd0); tick();
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0); #1;
        n_cmp++;
        if (ReadData1 !== 32'h00000001) begin
            n_err++; $display("FAIL midrst_rewrite: got %h, required 1", ReadData1);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        // both ports on the write target, then on r0 while writing
        drive(1'b1, 5'd20, 32'h13579BDF, 5'd20, 5'd20); #1;
        n_cmp++;
        if (ReadData1 !== 32'h13579BDF || ReadData2 !== 32'h13579BDF) begin
            n_err++; $display("FAIL dual_bypass: got %h/%h, required %h", ReadData1, ReadData2, 32'h13579BDF);
        end
        tick();
        drive(1'b1, 5'd21, 32'h2468ACE0, 5'd20, 5'd21); #1;
        n_cmp++;
        if (ReadData1 !== 32'h13579BDF || ReadData2 !== 32'h2468ACE0) begin
            n_err++; $display("FAIL b2b_read: got %h/%h, required %h/%h", ReadData1, ReadData2, 32'h13579BDF, 32'h2468ACE0);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] e1, e2, got;
        for (int n = 0; n < 300; n++) begin
            logic [4:0] wa, r1, r2;
            wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), wa, $urandom, r1, r2);
            #1;
            e1 = model_read(ReadReg1);
            e2 = model_read(ReadReg2);
            exp_q.push_back(e1);
            exp_q.push_back(e2);
            got = exp_q.pop_front();
            n_cmp++;
            if (ReadData1 !== got) begin
                n_err++; $display("FAIL rand_rd1 iter %0d idx %0d: got %h, required %h", n, ReadReg1, ReadData1, got);
            end
            got = exp_q.pop_front();
            n_cmp++;
            if (ReadData2 !== got) begin
                n_err++; $display("FAIL rand_rd2 iter %0d idx %0d: got %h, required %h", n, ReadReg2, ReadData2, got);
            end
            tick();
        end
        // final sweep of the whole file with writes off
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i);
            ReadReg2 = 5'(31 - i);
            #0.1;
            n_cmp++;
            if (ReadData1 !== model_read(ReadReg1) || ReadData2 !== model_read(ReadReg2)) begin
                n_err++;
                $display("FAIL rand_sweep idx %0d: got %h/%h, required %h/%h", i,
                         ReadData1, ReadData2, model_read(ReadReg1), model_read(ReadReg2));
            end
        end
        @(negedge clk);
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        model_clear();
        #1;
        n_cmp++;
        if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
            n_err++; $display("FAIL power_on_reset: got %h/%h, required 0/0", ReadData1, ReadData2);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_write_read();
        test_r0();
        test_bypass();
        test_no_write();
        test_reset();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_32x32.md
Name: reg_file_32x32

Overview:
- MIPS register file: 32 registers, 32 bits each.
- Two read ports and one write port.
- Sits directly upstream of the 32-bit ALU in the datapath:
  - ReadData1 drives ALU operand a.
  - ReadData2 drives ALU operand b through the ALUSrc mux.
- Write-back (ALU Result or memory data) returns on the write port.

Parameters:
- DATA_WIDTH, 32, width of each register and data port.
- ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH.

Ports:
- clk  input  1  clock; all writes on rising edge.
- reset  input  1  asynchronous, active-high; clears every register.
- ReadReg1  input  5  read port 1 register index (rs).
- ReadReg2  input  5  read port 2 register index (rt).
- WriteReg  input  5  write register index (rd/rt after RegDst mux).
- WriteData  input  32  write-back data.
- RegWrite  input  1  write enable, sampled on rising clk.
- ReadData1  output  32  contents of ReadReg1, feeds ALU a.
- ReadData2  output  32  contents of ReadReg2, feeds ALU b path.

Behaviour:
- Reset and clocking (already decided): one clock, clk; reset is asynchronous and active-high.
- Storage: 32 x 32-bit flops, regs[0..31].
- Reset: on reset assertion, all regs = 32'h0 immediately, independent of clk.
  - ReadData1/ReadData2 = 0 while reset is high.
  - Reset mid-write: the write is lost; reset wins.
- Write: on rising clk with reset low, RegWrite=1 and WriteReg!=0 → regs[WriteReg] <= WriteData.
  - RegWrite=0 → no register changes.
- Register 0: hardwired zero.
  - Writes to index 0 are discarded.
  - Reading index 0 always returns 0, including under bypass.
- Read: combinational, zero cycle latency from ReadRegN to ReadDataN.
- Write-through bypass (same-cycle write-back then read, required for single-cycle/pipelined WB→ID):
  - If RegWrite=1, WriteReg!=0 and WriteReg==ReadRegN, then ReadDataN = WriteData in the same cycle, before the edge.
  - After the edge the stored value matches, so the output is stable across the edge.
- Both read ports may address the same register; both return the identical value.
- Both read ports may match WriteReg simultaneously; both are bypassed.
- No X propagation: every output is defined from reset onward.
- Width rules: no arithmetic in the block; indices are full 5-bit, so out-of-range is impossible.
- Async reset style: regs use posedge clk / posedge reset sensitivity; bypass logic is purely combinational.

Test Plan:
- Assert reset with prior nonzero contents → all 32 reads (sweep ReadReg1/2 0..31) return 0 immediately, before any clk edge.
- RegWrite=1, WriteReg=5, WriteData=32'hDEADBEEF, clock; then RegWrite=0, ReadReg1=5, ReadReg2=5 → both 32'hDEADBEEF.
- RegWrite=1, WriteReg=0, WriteData=32'hFFFFFFFF, clock; ReadReg1=0 → 0; also during that cycle with ReadReg1=0 → 0 (no bypass to r0).
- Bypass: r7=32'h00000011 stored; drive RegWrite=1, WriteReg=7, WriteData=32'h00000022, ReadReg2=7 → ReadData2=32'h22 before the edge and after it.
- RegWrite=0, WriteReg=9, WriteData=32'h12345678, clock → r9 unchanged (0), and ReadData shows no bypass.
- Write r3=32'hA5A5A5A5, then raise reset midway between edges with RegWrite=1, WriteReg=3, WriteData=1 → ReadData1(r3)=0 immediately. Hold reset across an edge → still 0. Deassert, then write r3=1 → 1.
